// File: rtl/display_processor_pkg.sv
// Shared types and constants for the decode path of the processor.
//   imm_src_t    : immediate format chosen by the control unit
//   opcode_t     : base-ISA major opcodes seen in instr[6:0]
//   NOP_ENCODING : canonical no-op (addi x0, x0, 0) loaded on reset/flush
package display_processor_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_OP_IMM = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_OP     = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } opcode_t;

  localparam logic [31:0] NOP_ENCODING = {25'd0, OP_OP_IMM};

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file with write-through bypass.
//   clk, reset          : clock and asynchronous active-high reset
//   rs1_addr, rs2_addr  : combinational read indices
//   rs1_data, rs2_data  : read data (x0 reads 0; pending write forwarded)
//   we, wr_addr, wr_data: synchronous write port, writes to x0 ignored
module regfile_bypass #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // NOTE: the array is cleared by the asynchronous reset, so it maps to
  // flops rather than a RAM macro; that is intended for a register file
  // whose contents must read 0 straight after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A write landing this cycle is visible to the reader immediately, so
  // decode never sees the stale value of a register being written back.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    if (addr == '0)                  return '0;
    if (we && (wr_addr == addr))     return wr_data;
    return regs[addr];
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage with valid/ready handshake toward fetch and execute.
//   fetch side   : f_valid, f_ready, f_pc, f_instr
//   control      : d_flush (redirect), e_ready (execute backpressure)
//   to control   : op, funct3, funct7; from control: d_imm_src, d_uses_rs1/2
//   hazard input : e_valid, e_mem_read, e_rd (instruction in execute)
//   writeback    : w_reg_write, w_rd, w_result
//   to execute   : d_out_valid, d_pc, d_pc_plus_4, d_rs1/2, d_rd,
//                  d_rs1_value, d_rs2_value, d_imm_ext
module decode_stage
  import display_processor_pkg::*;
#(
  parameter  int          XLEN      = 32,
  parameter  int          NUM_REGS  = 32,
  localparam int          REG_AW    = $clog2(NUM_REGS),
  parameter  logic [31:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [XLEN-1:0]   f_pc,
  input  logic [31:0]       f_instr,
  input  logic              d_flush,
  input  logic              e_ready,
  output logic              d_out_valid,
  output logic [6:0]        op,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  input  imm_src_t          d_imm_src,
  input  logic              d_uses_rs1,
  input  logic              d_uses_rs2,
  input  logic              e_valid,
  input  logic              e_mem_read,
  input  logic [REG_AW-1:0] e_rd,
  input  logic              w_reg_write,
  input  logic [REG_AW-1:0] w_rd,
  input  logic [XLEN-1:0]   w_result,
  output logic [XLEN-1:0]   d_pc,
  output logic [XLEN-1:0]   d_pc_plus_4,
  output logic [REG_AW-1:0] d_rs1,
  output logic [REG_AW-1:0] d_rs2,
  output logic [REG_AW-1:0] d_rd,
  output logic [XLEN-1:0]   d_rs1_value,
  output logic [XLEN-1:0]   d_rs2_value,
  output logic [XLEN-1:0]   d_imm_ext
);

  logic        d_valid;
  logic [31:0] d_instr;
  logic        load_use;
  logic [31:0] imm32;

  // Field split; register indices are truncated to the configured width.
  assign op     = d_instr[6:0];
  assign funct3 = d_instr[14:12];
  assign funct7 = d_instr[31:25];
  assign d_rd   = d_instr[7  +: REG_AW];
  assign d_rs1  = d_instr[15 +: REG_AW];
  assign d_rs2  = d_instr[20 +: REG_AW];

  assign d_pc_plus_4 = d_pc + XLEN'(4);

  // A load in execute whose result this instruction needs is not ready
  // until after memory; hold decode one cycle and send a bubble instead.
  assign load_use = d_valid && e_valid && e_mem_read && (e_rd != '0) &&
                    ((d_uses_rs1 && (e_rd == d_rs1)) ||
                     (d_uses_rs2 && (e_rd == d_rs2)));

  assign d_out_valid = d_valid && !load_use;
  assign f_ready     = !d_valid || (d_out_valid && e_ready);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_valid <= 1'b0;
      d_pc    <= '0;
      d_instr <= NOP_INSTR;
    end else if (d_flush) begin
      // A redirect wins over both the hazard and a same-cycle fetch.
      d_valid <= 1'b0;
      d_instr <= NOP_INSTR;
    end else if (f_valid && f_ready) begin
      d_valid <= 1'b1;
      d_pc    <= f_pc;
      d_instr <= f_instr;
    end else if (f_ready) begin
      d_valid <= 1'b0;
    end
  end

  // NOTE: imm32 is assigned before the case so every path drives it and
  // no latch is inferred for the undefined formats.
  always_comb begin
    imm32 = '0;
    case (d_imm_src)
      IMM_I: imm32 = {{20{d_instr[31]}}, d_instr[31:20]};
      IMM_S: imm32 = {{20{d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
      IMM_B: imm32 = {{19{d_instr[31]}}, d_instr[31], d_instr[7],
                      d_instr[30:25], d_instr[11:8], 1'b0};
      IMM_U: imm32 = {d_instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{d_instr[31]}}, d_instr[31], d_instr[19:12],
                      d_instr[20], d_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every format is already sign-extended to 32 bits; widen for RV64.
  assign d_imm_ext = XLEN'($signed(imm32));

  regfile_bypass #(
    .XLEN    (XLEN),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs1_addr(d_rs1),
    .rs2_addr(d_rs2),
    .rs1_data(d_rs1_value),
    .rs2_data(d_rs2_value),
    .we      (w_reg_write),
    .wr_addr (w_rd),
    .wr_data (w_result)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: randomized traffic against a
// behavioural model, followed by directed reset/bypass/stall/flush cases.
module tb_decode_stage;
  import display_processor_pkg::*;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_valid, f_ready;
  logic [XLEN-1:0]   f_pc;
  logic [31:0]       f_instr;
  logic              d_flush, e_ready, d_out_valid;
  logic [6:0]        op, funct7;
  logic [2:0]        funct3;
  imm_src_t          d_imm_src;
  logic              d_uses_rs1, d_uses_rs2;
  logic              e_valid, e_mem_read;
  logic [REG_AW-1:0] e_rd, w_rd;
  logic              w_reg_write;
  logic [XLEN-1:0]   w_result;
  logic [XLEN-1:0]   d_pc, d_pc_plus_4, d_rs1_value, d_rs2_value, d_imm_ext;
  logic [REG_AW-1:0] d_rs1, d_rs2, d_rd;

  decode_stage #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_instr(f_instr),
    .d_flush(d_flush), .e_ready(e_ready), .d_out_valid(d_out_valid),
    .op(op), .funct3(funct3), .funct7(funct7),
    .d_imm_src(d_imm_src), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .e_valid(e_valid), .e_mem_read(e_mem_read), .e_rd(e_rd),
    .w_reg_write(w_reg_write), .w_rd(w_rd), .w_result(w_result),
    .d_pc(d_pc), .d_pc_plus_4(d_pc_plus_4),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_rs1_value(d_rs1_value), .d_rs2_value(d_rs2_value),
    .d_imm_ext(d_imm_ext)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid;
  logic [31:0] m_pc, m_instr;
  logic [31:0] m_regs [32];

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = '0;
    m_instr = NOP;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  // Immediate rebuilt arithmetically: weight each field by its bit position,
  // then apply two's-complement of the format's natural width.
  function automatic logic [31:0] ref_imm(input logic [31:0] i,
                                          input logic [2:0] src);
    longint raw;
    int     n;
    case (src)
      3'd0: begin raw = longint'(i[31:20]); n = 12; end
      3'd1: begin raw = longint'(i[31:25]) * 32 + longint'(i[11:7]); n = 12; end
      3'd2: begin
        raw = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
              longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        n = 13;
      end
      3'd3: begin raw = longint'(i[31:12]) * 4096; n = 32; end
      3'd4: begin
        raw = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
              longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        n = 21;
      end
      default: return 32'd0;
    endcase
    if (raw >= (longint'(1) << (n - 1))) raw = raw - (longint'(1) << n);
    return raw[31:0];
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    if (idx == 0) return 32'd0;
    if (w_reg_write && (int'(w_rd) == idx)) return w_result;
    return m_regs[idx];
  endfunction

  function automatic bit ref_load_use();
    int rs1 = int'(m_instr[19:15]);
    int rs2 = int'(m_instr[24:20]);
    return m_valid && e_valid && e_mem_read && (e_rd != 0) &&
           ((d_uses_rs1 && int'(e_rd) == rs1) || (d_uses_rs2 && int'(e_rd) == rs2));
  endfunction

  function automatic bit ref_out_valid();
    return m_valid && !ref_load_use();
  endfunction

  function automatic bit ref_f_ready();
    return !m_valid || (ref_out_valid() && e_ready);
  endfunction

  task automatic compare_all();
    longint next_pc = (longint'(m_pc) + 4) % (longint'(1) << 32);
    check("out_valid", d_out_valid, ref_out_valid());
    check("f_ready",   f_ready,     ref_f_ready());
    check("op",        op,          m_instr[6:0]);
    check("funct3",    funct3,      m_instr[14:12]);
    check("funct7",    funct7,      m_instr[31:25]);
    check("rd",        d_rd,        m_instr[11:7]);
    check("rs1",       d_rs1,       m_instr[19:15]);
    check("rs2",       d_rs2,       m_instr[24:20]);
    check("pc",        d_pc,        m_pc);
    check("pc_plus_4", d_pc_plus_4, next_pc[31:0]);
    check("rs1_value", d_rs1_value, ref_read(int'(m_instr[19:15])));
    check("rs2_value", d_rs2_value, ref_read(int'(m_instr[24:20])));
    check("imm_ext",   d_imm_ext,   ref_imm(m_instr, d_imm_src));
  endtask

  task automatic model_edge();
    bit fr;
    if (reset) begin
      model_reset();
      return;
    end
    fr = ref_f_ready();
    if (w_reg_write && w_rd != 0) m_regs[w_rd] = w_result;
    if (d_flush) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (f_valid && fr) begin
      m_valid = 1'b1;
      m_pc    = f_pc;
      m_instr = f_instr;
    end else if (fr) begin
      m_valid = 1'b0;
    end
  endtask

  // Entered at a falling edge with inputs already driven.
  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    f_valid = 0; f_pc = '0; f_instr = NOP; d_flush = 0; e_ready = 1;
    d_imm_src = IMM_I; d_uses_rs1 = 0; d_uses_rs2 = 0;
    e_valid = 0; e_mem_read = 0; e_rd = '0;
    w_reg_write = 0; w_rd = '0; w_result = '0;
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] instr);
    f_valid = 1; f_pc = pc; f_instr = instr;
    tick();
    f_valid = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      f_valid     = ($urandom_range(0, 3) != 0);
      f_pc        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (c % 50 == 7) f_pc = 32'hFFFF_FFFC;
      f_instr     = ins;
      d_flush     = ($urandom_range(0, 9) == 0);
      e_ready     = ($urandom_range(0, 3) != 0);
      d_imm_src   = imm_src_t'(3'($urandom_range(0, 7)));
      d_uses_rs1  = 1'($urandom_range(0, 1));
      d_uses_rs2  = 1'($urandom_range(0, 1));
      e_valid     = 1'($urandom_range(0, 1));
      e_mem_read  = 1'($urandom_range(0, 1));
      e_rd        = 5'($urandom_range(0, 7));
      w_reg_write = 1'($urandom_range(0, 1));
      w_rd        = 5'($urandom_range(0, 7));
      w_result    = $urandom;
      tick();
    end
    idle_inputs();

    // ---------------- reset mid-cycle ----------------
    #2 reset = 1;
    model_reset();
    #1;
    check("rst_out_valid", d_out_valid, 1'b0);
    check("rst_f_ready",   f_ready,     1'b1);
    check("rst_op",        op,          7'h13);
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    reset = 0;
    for (int i = 1; i < 32; i++) begin
      load(32'h1000 + 32'(i * 4), (32'(i) << 20) | (32'(i) << 15) | 32'h33);
      #1 check("rst_reg_read", d_rs1_value, 32'd0);
    end
    tick();

    // ---------------- bypass ----------------
    load(32'h100, 32'h0022_80B3);  // add x1, x5, x2
    w_reg_write = 1; w_rd = 5'd5; w_result = 32'hDEAD_BEEF;
    #1 check("bypass_same_cycle", d_rs1_value, 32'hDEAD_BEEF);
    tick();
    w_reg_write = 0;
    #1 check("bypass_persist", d_rs1_value, 32'hDEAD_BEEF);
    load(32'h104, 32'h0000_0033);  // add x0, x0, x0
    w_reg_write = 1; w_rd = 5'd0; w_result = 32'hFFFF_FFFF;
    #1 check("x0_bypass", d_rs1_value, 32'd0);
    tick();
    w_reg_write = 0;
    #1 check("x0_write", d_rs1_value, 32'd0);
    tick();

    // ---------------- backpressure ----------------
    load(32'h200, 32'h0010_0093);
    e_ready = 0; f_valid = 1; f_pc = 32'h300; f_instr = 32'h0020_0113;
    #1 check("bp_f_ready", f_ready, 1'b0);
    repeat (3) tick();
    #1 check("bp_hold_pc", d_pc, 32'h200);
    e_ready = 1;
    #1 check("bp_release_ready", f_ready, 1'b1);
    tick();
    f_valid = 0;
    #1 check("bp_next_pc", d_pc, 32'h300);
    tick();

    // ---------------- load-use ----------------
    load(32'h500, 32'h0022_80B3);  // add x1, x5, x2
    d_uses_rs1 = 1; e_valid = 1; e_mem_read = 1; e_rd = 5'd5;
    f_valid = 1; f_pc = 32'h504; f_instr = 32'h0010_0093;
    #1 check("lu_out_valid", d_out_valid, 1'b0);
    check("lu_f_ready", f_ready, 1'b0);
    tick();
    e_mem_read = 0;
    #1 check("lu_clear", d_out_valid, 1'b1);
    e_mem_read = 1; e_rd = 5'd0;
    #1 check("lu_x0", d_out_valid, 1'b1);
    f_valid = 0;
    tick();
    idle_inputs();

    // ---------------- flush ----------------
    load(32'h600, 32'h0030_0193);
    d_flush = 1; f_valid = 1; f_pc = 32'h700; f_instr = 32'h0050_0093;
    tick();
    d_flush = 0; f_valid = 0;
    #1 check("flush_valid", d_out_valid, 1'b0);
    check("flush_op", op, 7'h13);
    check("flush_rd", d_rd, 5'd0);
    tick();

    // ---------------- immediate and wrap ----------------
    d_imm_src = IMM_B;
    load(32'hFFFF_FFFC, 32'hFE00_0EE3);  // beq x0, x0, -4
    #1 check("imm_b", d_imm_ext, 32'hFFFF_FFFC);
    check("pc_wrap", d_pc_plus_4, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised decode stage with valid/ready handshake, replacing the stall/flush-only decode.
- Captures a fetched instruction and PC into its pipeline register and splits the instruction fields for the control unit.
- Reads a bypassed register file and sign-extends the immediate to XLEN.
- Detects load-use hazards internally and inserts bubbles toward execute.
- Sits between fetch and execute; the control unit and writeback attach as in the current pipeline.

Parameters:
XLEN, 32, datapath and PC width in bits; legal values 32 or 64.
NUM_REGS, 32, architectural register count; must be a power of two, 2..32.
REG_AW, $clog2(NUM_REGS), register index width; derived, not overridden.
NOP_INSTR, 32'h0000_0013, instruction value loaded on reset or flush.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
f_valid  in  1  fetch presents a valid instruction
f_ready  out  1  decode accepts from fetch this cycle
f_pc  in  XLEN  PC of the fetched instruction
f_instr  in  32  fetched instruction
d_flush  in  1  kill the held instruction (branch redirect)
e_ready  in  1  execute accepts this cycle
d_out_valid  out  1  decoded bundle valid toward execute
op  out  7  opcode field, to the control unit
funct3  out  3  instruction [14:12]
funct7  out  7  instruction [31:25]
d_imm_src  in  imm_src_t  immediate format, from the control unit
d_uses_rs1  in  1  instruction reads rs1, from the control unit
d_uses_rs2  in  1  instruction reads rs2, from the control unit
e_valid  in  1  execute holds a valid instruction
e_mem_read  in  1  execute instruction is a load
e_rd  in  REG_AW  destination register of the execute instruction
w_reg_write  in  1  writeback register write enable
w_rd  in  REG_AW  writeback destination register
w_result  in  XLEN  writeback data
d_pc, d_pc_plus_4  out  XLEN each  held PC and PC+4
d_rs1, d_rs2, d_rd  out  REG_AW each  register indices (instruction bits truncated to REG_AW)
d_rs1_value, d_rs2_value  out  XLEN each  register operands
d_imm_ext  out  XLEN  sign-extended immediate

Behaviour:
- State: d_valid, d_pc, d_instr. On reset, asynchronously: d_valid=0, d_pc=0, d_instr=NOP_INSTR, all registers=0.
- d_pc_plus_4 = d_pc + 4, computed combinationally and truncated to XLEN, so it wraps (0xFFFFFFFC gives 0).
- Field outputs decode d_instr combinationally.
  - After reset they show NOP_INSTR fields: op=0x13, d_rd=0, d_imm_ext=0.
- Load-use hazard:
  - lu = d_valid & e_valid & e_mem_read & (e_rd != 0).
  - It also requires a match: (d_uses_rs1 & e_rd == d_rs1) | (d_uses_rs2 & e_rd == d_rs2).
- d_out_valid = d_valid & ~lu. A transfer to execute happens when d_out_valid & e_ready.
- f_ready = ~d_valid | (d_out_valid & e_ready). This is combinational and is not a function of f_valid.
- Next-state priority, highest first:
  1. d_flush: d_valid<=0 and d_instr<=NOP_INSTR. Any same-cycle fetch is dropped even if f_ready=1; fetch must re-present it.
  2. f_valid & f_ready: load f_pc and f_instr, d_valid<=1.
  3. f_ready & ~f_valid: d_valid<=0.
  4. Otherwise hold every register (stall, including lu).
- Latency: one cycle from fetch acceptance to d_out_valid. Full throughput of one instruction per cycle when there is no backpressure.
- Register file:
  - Two combinational read ports and one synchronous write port; writes land on the rising edge.
  - Index 0 reads 0, and writes to it are ignored.
  - Write-through bypass: if w_reg_write & w_rd==rsN & rsN!=0, then rsN_value = w_result in the same cycle.
- Immediate formats, each sign-extended from instr[31] to XLEN:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - An undefined imm_src value gives 0.
- Simultaneous hazard and flush: the flush wins and the bubble is dropped.
- Reset asserted mid-transfer discards the held instruction; register contents are cleared.

Decomposition:
- Shared package display_processor_pkg holds:
  - imm_src_t (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J)
  - opcode_t
  - the NOP constant
- One sub-module, regfile_bypass, parametrised on XLEN and NUM_REGS. It contains the storage, async reset, x0 rule and write-through bypass.
- Immediate extension stays inline.

Test Plan:
1. Reset: assert reset mid-cycle -> d_out_valid=0, f_ready=1, op=0x13, reads of x1..x31 = 0 before any writes.
2. Bypass:
   - w_reg_write=1, w_rd=5, w_result=0xDEADBEEF while d_rs1=5 -> d_rs1_value=0xDEADBEEF in the same cycle, and it persists after the edge.
   - w_rd=0 -> x0 still reads 0.
3. Backpressure:
   - e_ready=0 with d_valid=1 -> f_ready=0; d_pc and d_instr stay stable for 3 cycles.
   - e_ready=1 -> transfer happens and the next instruction loads on the following edge.
4. Load-use:
   - e_valid=1, e_mem_read=1, e_rd=5; decoded add x1,x5,x2 with d_uses_rs1=1 -> d_out_valid=0, f_ready=0.
   - Next cycle with e_mem_read=0 -> d_out_valid=1.
   - e_rd=0 never stalls.
5. Flush: d_flush=1 together with f_valid=1 -> next cycle d_valid=0 and op=0x13; the fetched instruction is not captured.
6. Immediate and wrap:
   - f_instr=0xFE000EE3 (beq x0,x0,-4) with IMM_B -> d_imm_ext=0xFFFFFFFC.
   - f_pc=0xFFFFFFFC -> d_pc_plus_4=0x00000000.
